// File: rtl/sparse_expand_13_if.sv
// Interface: sparse_expand_13_if
// Purpose: groups the three handshake channels of the sparse expander.
//   The header channel carries the mask and count. The value channel carries one
//   nonzero value per beat. The output channel carries the dense lane vector. The
//   cnt_err flag rides along with them.
// Parameters:
//   DATA_W     width of one lane value
// Signals:
//   hdr_valid/hdr_ready/hdr_mask[12:0]/hdr_cnt[3:0]   header channel
//   val_valid/val_ready/val_data[DATA_W-1:0]          value channel
//   out_valid/out_ready/out_data[13*DATA_W-1:0]       dense vector channel
//   cnt_err                                           header count mismatch pulse
// Modports:
//   master     environment side: drives headers, values and out_ready
//   slave      expander side
interface sparse_expand_13_if #(
    parameter int DATA_W = 8
);
    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [12:0]            hdr_mask;
    logic [3:0]             hdr_cnt;
    logic                   val_valid;
    logic                   val_ready;
    logic [DATA_W-1:0]      val_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [13*DATA_W-1:0]   out_data;
    logic                   cnt_err;

    modport master (
        output hdr_valid, hdr_mask, hdr_cnt, val_valid, val_data, out_ready,
        input  hdr_ready, val_ready, out_valid, out_data, cnt_err
    );

    modport slave (
        input  hdr_valid, hdr_mask, hdr_cnt, val_valid, val_data, out_ready,
        output hdr_ready, val_ready, out_valid, out_data, cnt_err
    );
endinterface

// File: rtl/sparse_expand_13.sv
// Module: sparse_expand_13
// Purpose: rebuilds a dense 13-lane vector from a compressed stream. The stream is
//   a header (occupancy mask + popcount) followed by one value beat per set mask
//   bit. Values land in their lanes in ascending lane order, and empty lanes read 0.
// Parameters:
//   DATA_W     width of one lane value
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        sparse_expand_13_if slave modport (header, value and output channels
//              plus the cnt_err pulse)
module sparse_expand_13 #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    sparse_expand_13_if.slave   bus
);
    localparam int LANES = 13;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [LANES-1:0]       rem;
    logic [LANES-1:0]       low_bit;
    logic [LANES-1:0]       rem_cleared;
    logic [3:0]             pop;
    logic [DATA_W-1:0]      lane [LANES];
    logic [LANES*DATA_W-1:0] out_flat;
    logic                   hdr_ready_q;
    logic                   val_ready_q;
    logic                   out_valid_q;
    logic                   cnt_err_q;
    logic                   hdr_fire;
    logic                   val_fire;
    logic                   out_fire;

    assign hdr_fire = bus.hdr_valid && hdr_ready_q;
    assign val_fire = bus.val_valid && val_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Two's-complement trick isolates the lowest pending lane as a one-hot vector.
    assign low_bit     = rem & (~rem + 13'd1);
    assign rem_cleared = rem & ~low_bit;

    // Our own popcount of the incoming mask; hdr_cnt is only cross-checked against it.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + {3'b000, bus.hdr_mask[i]};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (hdr_fire) next_state = (bus.hdr_mask == '0) ? OUT : FILL;
            FILL: if (val_fire && (rem_cleared == '0)) next_state = OUT;
            OUT:  if (out_fire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The ready/valid flags are registered from next_state. This way hdr_ready stays
    // low while reset is held and only rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rem         <= '0;
            hdr_ready_q <= 1'b0;
            val_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_err_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) lane[i] <= '0;
        end else begin
            state       <= next_state;
            hdr_ready_q <= (next_state == IDLE);
            val_ready_q <= (next_state == FILL);
            out_valid_q <= (next_state == OUT);
            cnt_err_q   <= hdr_fire && (pop != bus.hdr_cnt);
            if (hdr_fire) begin
                rem <= bus.hdr_mask;
                for (int i = 0; i < LANES; i++) lane[i] <= '0;
            end else if (val_fire) begin
                rem <= rem_cleared;
                for (int i = 0; i < LANES; i++) begin
                    if (low_bit[i]) lane[i] <= bus.val_data;
                end
            end
        end
    end

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < LANES; i++) out_flat[i*DATA_W +: DATA_W] = lane[i];
    end

    assign bus.hdr_ready = hdr_ready_q;
    assign bus.val_ready = val_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_flat;
    assign bus.cnt_err   = cnt_err_q;
endmodule

// File: tb/tb_sparse_expand_13.sv
// Module: tb_sparse_expand_13
// Purpose: directed self-checking bench for sparse_expand_13. Each packet's dense
//   vector is computed by a small reference expander. The result is queued when the
//   header is driven, and it is popped when the DUT presents the vector.
// Ports: none (top-level bench)
module tb_sparse_expand_13;
    localparam int DATA_W = 8;
    localparam int LANES  = 13;
    localparam int W      = LANES * DATA_W;

    typedef logic [DATA_W-1:0] vals_t [LANES];

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    sparse_expand_13_if #(.DATA_W(DATA_W)) bus ();

    sparse_expand_13 #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [$];

    // Reference expander: walk the lanes in ascending order, handing out values in sequence.
    function automatic logic [W-1:0] model_expand(input logic [12:0] mask, input vals_t vals);
        logic [W-1:0] r = '0;
        int k = 0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                r[i*DATA_W +: DATA_W] = vals[k];
                k++;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one header once hdr_ready is seen and returns the cnt_err value from the following cycle.
    task automatic apply_stimulus_header(input logic [12:0] mask, input logic [3:0] cnt,
                                         output logic err);
        bit done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.hdr_ready === 1'b1) begin
                bus.hdr_valid = 1'b1;
                bus.hdr_mask  = mask;
                bus.hdr_cnt   = cnt;
                done = 1;
            end
        end
        check("hdr_accept", W'(done), W'(1));
        @(negedge clk);
        bus.hdr_valid = 1'b0;
        err = bus.cnt_err;
    endtask

    // Sends n value beats. Each beat is followed by 'gap' idle cycles.
    task automatic apply_stimulus_values(input vals_t vals, input int n, input int gap);
        int idx = 0;
        for (int c = 0; c < 300 && idx < n; c++) begin
            @(negedge clk);
            if (bus.val_ready === 1'b1 && (c % (gap + 1)) == 0) begin
                bus.val_valid = 1'b1;
                bus.val_data  = vals[idx];
                idx++;
            end else begin
                bus.val_valid = 1'b0;
            end
        end
        check("val_accept", W'(idx == n), W'(1));
        @(negedge clk);
        bus.val_valid = 1'b0;
    endtask

    // Waits for out_valid, stalls out_ready for 'hold' cycles, and then completes the handshake.
    task automatic check_output(input string tag, input int hold);
        bit seen = 0;
        bit bad_hold = 0;
        logic [W-1:0] expv = 'x;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_valid"}, W'(seen), W'(1));
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            if (bus.out_valid !== 1'b1 || bus.hdr_ready !== 1'b0 ||
                bus.val_ready !== 1'b0 || bus.out_data !== expv) bad_hold = 1;
            @(negedge clk);
        end
        if (hold > 0) check({tag, "_hold"}, W'(bad_hold), W'(0));
        bus.out_ready = 1'b1;
        check({tag, "_data"}, bus.out_data, expv);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle"}, W'({bus.out_valid, bus.hdr_ready}), W'(2'b01));
    endtask

    initial begin
        vals_t v;
        logic  err;
        logic [12:0] mask;

        bus.hdr_valid = 1'b0;
        bus.hdr_mask  = '0;
        bus.hdr_cnt   = '0;
        bus.val_valid = 1'b0;
        bus.val_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_flags", W'({bus.hdr_ready, bus.val_ready, bus.out_valid, bus.cnt_err}), W'(0));
        check("rst_data", bus.out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_hdr_ready", W'(bus.hdr_ready), W'(1));

        // T1: full mask with values 1..13, back to back.
        for (int i = 0; i < LANES; i++) v[i] = DATA_W'(i + 1);
        mask = 13'h1FFF;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd13, err);
        check("t1_cnt_err", W'(err), W'(0));
        apply_stimulus_values(v, 13, 0);
        check("t1_latency", W'(bus.out_valid), W'(1));
        check_output("t1", 0);

        // T2: sparse mask with stalls between beats.
        v = '{default: '0};
        v[0] = 8'hAA; v[1] = 8'hBB; v[2] = 8'hCC;
        mask = 13'h1005;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd3, err);
        check("t2_cnt_err", W'(err), W'(0));
        apply_stimulus_values(v, 3, 2);
        check_output("t2", 0);

        // T3: empty mask goes straight to output.
        v = '{default: '0};
        mask = 13'h0000;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd0, err);
        check("t3_latency", W'({bus.out_valid, bus.val_ready}), W'(2'b10));
        check_output("t3", 0);

        // T4: wrong header count; a zero value beat is legal.
        v = '{default: '0};
        v[0] = 8'h5A; v[1] = 8'h00;
        mask = 13'h0003;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd5, err);
        check("t4_cnt_err_pulse", W'(err), W'(1));
        @(negedge clk);
        check("t4_cnt_err_single", W'(bus.cnt_err), W'(0));
        apply_stimulus_values(v, 2, 0);
        check_output("t4", 0);

        // T5: downstream back-pressure for 10 cycles.
        v = '{default: '0};
        v[0] = 8'h11; v[1] = 8'h22;
        mask = 13'h0810;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd2, err);
        apply_stimulus_values(v, 2, 0);
        check_output("t5", 10);

        // T6: reset after 2 of 5 beats drops the packet; the next packet must be clean.
        v = '{default: '0};
        for (int i = 0; i < 5; i++) v[i] = DATA_W'(8'hE0 + i);
        apply_stimulus_header(13'h001F, 4'd5, err);
        apply_stimulus_values(v, 2, 0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_flags", W'({bus.hdr_ready, bus.val_ready, bus.out_valid, bus.cnt_err}), W'(0));
        check("t6_rst_data", bus.out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        v = '{default: '0};
        v[0] = 8'h77; v[1] = 8'h88;
        mask = 13'h1100;
        exp_q.push_back(model_expand(mask, v));
        apply_stimulus_header(mask, 4'd2, err);
        apply_stimulus_values(v, 2, 0);
        check_output("t6_clean", 0);

        check("sb_empty", W'(exp_q.size() == 0), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
